// File: rtl/mdu_ctrl.sv
// mdu_ctrl: E-stage multiply/divide sequencer owning HI/LO; results commit N cycles after accept.
// md_stall holds D-stage MDU ops while busy. Optional madd/msub ops under `MDU_MADD_EN.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_md,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] rd_data,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [31:0]   hi_s, lo_s;
  logic          is_mult, is_div, is_madd, is_long, accept, commit;
  logic [63:0]   sprod, uprod, res;
  logic [31:0]   bdiv, squo, srem, uquo, urem;

  assign is_mult = (op == 4'd1) || (op == 4'd2);
  assign is_div  = (op == 4'd3) || (op == 4'd4);
`ifdef MDU_MADD_EN
  assign is_madd = (op >= 4'd9) && (op <= 4'd12);
`else
  assign is_madd = 1'b0;
`endif
  assign is_long = is_mult || is_div || is_madd;
  assign busy    = (state == RUN);
  assign accept  = start && (op != 4'd0) && !busy;

  assign md_stall = d_md && (busy || (start && is_long));
  assign rd_data  = (op == 4'd7) ? hi : (op == 4'd8) ? lo : 32'd0;

  assign sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign uprod = {32'd0, a} * {32'd0, b};

  // Divisor forced to 1 on zero so the dividers never see x/0; result is discarded then.
  assign bdiv = (b == 32'd0) ? 32'd1 : b;
  assign squo = $signed(a) / $signed(bdiv);
  assign srem = $signed(a) % $signed(bdiv);
  assign uquo = a / bdiv;
  assign urem = a % bdiv;

  // Divide by zero keeps the current HI/LO as the shadow value, so the commit is a no-op.
  always_comb begin
    res = {hi, lo};
    case (op)
      4'd1: res = sprod;
      4'd2: res = uprod;
      4'd3: if (b != 32'd0) res = {srem, squo};
      4'd4: if (b != 32'd0) res = {urem, uquo};
`ifdef MDU_MADD_EN
      4'd9:  res = {hi, lo} + sprod;
      4'd10: res = {hi, lo} + uprod;
      4'd11: res = {hi, lo} - sprod;
      4'd12: res = {hi, lo} - uprod;
`endif
      default: res = {hi, lo};
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (accept && is_long) begin
          state_nxt = RUN;
          cnt_nxt   = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end
      end
      RUN: begin
        if (cnt == CW'(1)) begin
          commit    = 1'b1;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      hi_s  <= 32'd0;
      lo_s  <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept && is_long) begin
        hi_s <= res[63:32];
        lo_s <= res[31:0];
      end
      if (commit) begin
        hi <= hi_s;
        lo <= lo_s;
      end else if (accept && (op == 4'd5)) begin
        hi <= a;
      end else if (accept && (op == 4'd6)) begin
        lo <= a;
      end
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: driver pushes expected HI/LO and busy length, monitor checks on busy fall.
module tb_mdu_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;
`ifdef MDU_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif

  logic        clk, reset, start, d_md;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy, md_stall;
  logic [31:0] rd_data, hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_hi, m_lo;
  int          n_pass, n_total;

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .d_md(d_md),
    .busy(busy), .md_stall(md_stall), .rd_data(rd_data), .hi(hi), .lo(lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic bit is_long(input logic [3:0] o);
    return (o >= 4'd1 && o <= 4'd4) || (MADD && o >= 4'd9 && o <= 4'd12);
  endfunction

  // Reference: plain integer arithmetic on the architectural {HI,LO} value.
  function automatic logic [63:0] ref_result(input logic [3:0] o, input logic [31:0] x,
                                             input logic [31:0] y, input logic [63:0] acc);
    int                sx = x;
    int                sy = y;
    int unsigned       ux = x;
    int unsigned       uy = y;
    longint            sp = longint'(sx) * longint'(sy);
    longint unsigned   up = 64'(ux) * 64'(uy);
    logic [63:0]       r  = acc;
    case (o)
      4'd1:  r = sp;
      4'd2:  r = up;
      4'd3:  if (y != 0) r = {32'(sx % sy), 32'(sx / sy)};
      4'd4:  if (y != 0) r = {32'(ux % uy), 32'(ux / uy)};
      4'd9:  r = acc + sp;
      4'd10: r = acc + up;
      4'd11: r = acc - sp;
      4'd12: r = acc - up;
      default: r = acc;
    endcase
    return r;
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge in the first idle cycle.
  task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic dm, input int rst_at, input bit poke);
    exp_t        e;
    logic [63:0] r;
    bit          lng, done;
    int          k, guard;
    lng = is_long(o);
    start = 1'b1; op = o; a = x; b = y; d_md = dm;
    #1;
    chk("md_stall_accept", md_stall, dm & lng);
    chk("rd_data", rd_data, (o == 4'd7) ? m_hi : (o == 4'd8) ? m_lo : 32'd0);
    if (lng) begin
      r = ref_result(o, x, y, {m_hi, m_lo});
      e.cycles = (o == 4'd3 || o == 4'd4) ? DC : MC;
      if (rst_at > 0) begin
        r = 64'd0;
        e.cycles = rst_at;
      end
      e.hi = r[63:32];
      e.lo = r[31:0];
      exp_q.push_back(e);
      m_hi = r[63:32];
      m_lo = r[31:0];
    end else if (o == 4'd5) begin
      m_hi = x;
    end else if (o == 4'd6) begin
      m_lo = x;
    end
    @(posedge clk);
    #1;
    start = 1'b0; op = 4'd0;
    if (!lng) begin
      chk("busy_short", busy, 1'b0);
      chk("hi_short", hi, m_hi);
      chk("lo_short", lo, m_lo);
      @(negedge clk);
      return;
    end
    chk("busy_rise", busy, 1'b1);
    if (poke) begin
      start = 1'b1; op = 4'd1; a = 32'd5; b = 32'd5;
    end
    done = 1'b0; guard = 0; k = 0;
    while (!done && guard < 64) begin
      @(negedge clk);
      guard++;
      if (busy) begin
        k++;
        #1;
        chk("md_stall_busy", md_stall, dm);
        if (rst_at > 0 && k == rst_at) reset = 1'b1;
      end else begin
        reset = 1'b0; start = 1'b0; op = 4'd0;
        #1;
        chk("md_stall_idle", md_stall, 1'b0);
        done = 1'b1;
      end
    end
    if (!done) chk("busy_timeout", busy, 1'b0);
  endtask

  // Monitor: each busy fall is one completed (or reset-aborted) long op.
  initial begin
    logic prev;
    int   len;
    exp_t e;
    prev = 1'b0;
    len  = 0;
    forever begin
      @(negedge clk);
      if (busy) begin
        len++;
      end else if (prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk("busy_len", len, e.cycles);
          chk("hi_done", hi, e.hi);
          chk("lo_done", lo, e.lo);
        end
        len = 0;
      end
      prev = busy;
    end
  end

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 4))
      0:       return $urandom;
      1:       return $urandom_range(0, 20);
      2:       return -$urandom_range(1, 20);
      3:       return ($urandom_range(0, 1) == 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    logic [3:0]  ro;
    logic [31:0] ra, rb;
    n_pass = 0; n_total = 0;
    m_hi = 32'd0; m_lo = 32'd0;
    reset = 1'b1; start = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0; d_md = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_stall", md_stall, 1'b0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_rd", rd_data, 32'd0);
    reset = 1'b0;

    do_op(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 0, 1'b0);
    do_op(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 0, 1'b0);
    do_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 0, 1'b0);
    do_op(4'd4, 32'd7, 32'd0, 1'b0, 0, 1'b0);
    do_op(4'd1, 32'd3, 32'd4, 1'b1, 0, 1'b0);
    do_op(4'd2, 32'd3, 32'd4, 1'b0, 0, 1'b0);
    do_op(4'd3, 32'd100, 32'd3, 1'b0, 0, 1'b1);
    do_op(4'd1, 32'd12345, 32'd678, 1'b0, 3, 1'b0);
    repeat (8) @(negedge clk);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    do_op(4'd5, 32'h1234, 32'd0, 1'b0, 0, 1'b0);
    do_op(4'd7, 32'd0, 32'd0, 1'b1, 0, 1'b0);
    do_op(4'd6, 32'hCAFE, 32'd0, 1'b0, 0, 1'b0);
    do_op(4'd8, 32'd0, 32'd0, 1'b0, 0, 1'b0);
    do_op(4'd5, 32'd0, 32'd0, 1'b0, 0, 1'b0);
    do_op(4'd6, 32'd1, 32'd0, 1'b0, 0, 1'b0);
    do_op(4'd9, 32'd2, 32'd3, 1'b1, 0, 1'b0);
    do_op(4'd12, 32'd1, 32'd8, 1'b0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ro = 4'($urandom_range(1, 12));
      ra = rand_operand();
      rb = rand_operand();
      if (ro == 4'd3 && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
      do_op(ro, ra, rb, 1'($urandom_range(0, 1)), 0, 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    chk("final_hi", hi, m_hi);
    chk("final_lo", lo, m_lo);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide unit and sequencer for the pipelined CPU's E stage. It accepts MDU operations from the E-stage control signals, runs multi-cycle mult/div on a busy counter, and owns the HI/LO registers. It raises a stall request toward the hazard unit so the D stage holds any MDU instruction while a computation is in flight.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy duration for mult/multu (≥1).
- `DIV_CYCLES`, default 10: busy duration for div/divu (≥1).

Ports:
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: E-stage instruction is a valid MDU op this cycle.
- `op`  in  4: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9 madd, 10 maddu, 11 msub, 12 msubu. 9–12 exist only under `MDU_MADD_EN`.
- `a`  in  32: rs operand (forwarded).
- `b`  in  32: rt operand (forwarded).
- `d_md`  in  1: D-stage instruction is any MDU op (1–12).
- `busy`  out  1: computation in flight.
- `md_stall`  out  1: stall request to the hazard unit.
- `rd_data`  out  32: HI if op=mfhi, LO if op=mflo, else 0.
- `hi`, `lo`  out  32 each: architectural HI/LO registers.

## Operation
- Two states: IDLE (busy=0) and RUN (busy=1). A down-counter `cnt` (width ⌈log2(max(MULT_CYCLES,DIV_CYCLES)+1)⌉) sets the RUN duration.
- Accept rule: an op is accepted when start=1, op≠0 and busy=0. When busy=1, start is ignored; the hazard unit guarantees this does not happen. The bench checks that nothing changes.
- mult: {HI,LO}_next = signed(a)×signed(b), 64-bit. multu: unsigned product.
- div: LO_next = signed a/b, truncated toward zero. HI_next = remainder, with the sign of a. divu: unsigned quotient and remainder.
- Divide by zero: the op still runs the full DIV_CYCLES, then HI and LO stay unchanged.
- On accept of op 1–4 (or 9–12):
  - Compute the result into shadow registers `hi_s`/`lo_s`.
  - Load cnt with MULT_CYCLES or DIV_CYCLES and go to RUN.
  - In RUN, cnt decrements each cycle. When cnt reaches 1 at a clock edge, commit the shadow registers to HI/LO, set cnt to 0 and return to IDLE.
- mthi/mtlo: when accepted, HI←a or LO←a at the next edge. Takes 0 busy cycles.
- mfhi/mflo: combinational read of the current HI/LO on rd_data. No state change.
- md_stall = d_md & (busy | (start & op∈{1,2,3,4,9..12})).
- Reset (including during RUN): HI=LO=0, shadow registers=0, cnt=0, IDLE. Any in-flight result is discarded.

## Timing
- Reset values: busy=0, md_stall=0 (given d_md=0), hi=lo=0, rd_data=0.
- An op accepted at edge E0 gives:
  - busy=1 for exactly N cycles after E0 (N = MULT_CYCLES or DIV_CYCLES).
  - HI/LO update at edge E0+N, when busy falls.
  - New values visible from cycle E0+N onward.
- Back-to-back: a new mult/div can be accepted in the first cycle that busy=0. There is no dead cycle.
- mthi/mtlo accepted at edge E0 give a new HI/LO value visible after E0.
- rd_data and md_stall are combinational with zero latency.

## Configuration
- `MDU_MADD_EN`:
  - Defined: ops 9–12 are accepted and take MULT_CYCLES. The result is {HI,LO}_next = {HI,LO} ± product, signed or unsigned per op. The HI/LO value used is the one sampled at accept, and the result wraps modulo 2^64.
  - Undefined: ops 9–12 behave as op 0 (ignored, no busy) and are not counted in md_stall.

## Test plan
- Reset → busy=0, hi=lo=0. Then mult a=0xFFFFFFFF, b=2 → busy high for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. With multu on the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- div a=-7 (0xFFFFFFF9), b=2 → busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu a=7, b=0 → busy 10 cycles, HI/LO unchanged.
- Stall: hold d_md=1 from the accept cycle → md_stall=1 in the accept cycle and for all 5 busy cycles, then 0. With d_md=0 → md_stall=0 throughout.
- Start while busy: issue div a=100, b=3; during RUN drive start=1, op=mult a=5, b=5 → ignored, result LO=33, HI=1, busy length unaffected.
- Reset asserted on busy cycle 3 of a mult → the next cycle has busy=0, HI=LO=0, and the product is never committed. Then mthi a=0x1234 → HI=0x1234 the next cycle, and mfhi rd_data=0x1234.
- `MDU_MADD_EN`: with HI=0, LO=1, madd a=2, b=3 → after 5 cycles HI=0, LO=7. msubu a=1, b=8 from HI=0, LO=7 → HI=0xFFFFFFFF, LO=0xFFFFFFFF.
